// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-counter sequencer for the BRISC core. Steps the
//             instruction address once per cycle after program load, with
//             absolute jump, call/return through an internal LIFO
//             return-address stack, stall, and a halt at LAST_ADDR.
//  Ports    : CLK, RST_N (async, active-low)
//             load_done, stall, jump_en, call_en, ret_en, jump_address
//             program_counter, running, halted, stack_level,
//             stack_overflow, stack_underflow (all registered)
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 4,
    parameter int LAST_ADDR   = 2**ADDR_W - 1
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             load_done,
    input  logic                             stall,
    input  logic                             jump_en,
    input  logic                             call_en,
    input  logic                             ret_en,
    input  logic [ADDR_W-1:0]                jump_address,
    output logic [ADDR_W-1:0]                program_counter,
    output logic                             running,
    output logic                             halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
    output logic                             stack_overflow,
    output logic                             stack_underflow
);

    localparam int                LVL_W       = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(LAST_ADDR);
    localparam logic [LVL_W-1:0]  c_depth     = LVL_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] top_entry;

    // Natural wrap of the adder gives the required mod 2**ADDR_W push value.
    assign pc_inc = pc_q + ADDR_W'(1);

    // Top of stack is the entry just below the current fill level.
    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (LVL_W'(i + 1) == level_q) begin
                top_entry = stack_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        level_d = level_q;
        stack_d = stack_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (load_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN, ST_HALT: begin
                if (!load_done) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    level_d = '0;
                end else if (stall) begin
                    // Freeze everything.
                end else if (ret_en) begin
                    if (level_q != '0) begin
                        pc_d    = top_entry;
                        level_d = level_q - LVL_W'(1);
                        state_d = ST_RUN;
                    end else begin
                        unf_d = 1'b1;
                        // A failed return in HALT leaves the PC parked.
                        if (state_q == ST_RUN) begin
                            pc_d = pc_inc;
                        end
                    end
                end else if (call_en) begin
                    if (level_q < c_depth) begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (LVL_W'(i) == level_q) begin
                                stack_d[i] = pc_inc;
                            end
                        end
                        pc_d    = jump_address;
                        level_d = level_q + LVL_W'(1);
                        state_d = ST_RUN;
                    end else begin
                        ovf_d = 1'b1;
                        if (state_q == ST_RUN) begin
                            pc_d = pc_inc;
                        end
                    end
                end else if (jump_en) begin
                    pc_d    = jump_address;
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN) begin
                    if (pc_q == c_last_addr) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                level_d = '0;
            end
        endcase

        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            level_q   <= '0;
            stack_q   <= '{default: '0};
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            level_q   <= level_d;
            stack_q   <= stack_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    assign program_counter = pc_q;
    assign running         = running_q;
    assign halted          = halted_q;
    assign stack_level     = level_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer. A behavioural model
//             (integer PC, queue-based return stack) predicts every output
//             after each clock; directed scenarios are followed by a long
//             randomized run with occasional asynchronous resets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int LAST  = 31;
    localparam int LVLW  = $clog2(DEPTH + 1);
    localparam int MODV  = 2**AW;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            load_done = 1'b0;
    logic            stall = 1'b0;
    logic            jump_en = 1'b0;
    logic            call_en = 1'b0;
    logic            ret_en = 1'b0;
    logic [AW-1:0]   jump_address = '0;
    logic [AW-1:0]   program_counter;
    logic            running;
    logic            halted;
    logic [LVLW-1:0] stack_level;
    logic            stack_overflow;
    logic            stack_underflow;

    pc_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .LAST_ADDR   (LAST)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .load_done       (load_done),
        .stall           (stall),
        .jump_en         (jump_en),
        .call_en         (call_en),
        .ret_en          (ret_en),
        .jump_address    (jump_address),
        .program_counter (program_counter),
        .running         (running),
        .halted          (halted),
        .stack_level     (stack_level),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = idle, 1 = run, 2 = halt.
    int m_state;
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_stk.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic model_step(input bit ld, input bit st, input bit j, input bit c,
                              input bit r, input int ja);
        if (m_state == 0) begin
            m_pc = 0;
            if (ld) m_state = 1;
        end else if (!ld) begin
            m_state = 0;
            m_pc    = 0;
            m_stk.delete();
        end else if (st) begin
            // nothing moves
        end else if (r) begin
            if (m_stk.size() > 0) begin
                m_pc    = m_stk.pop_back();
                m_state = 1;
            end else begin
                m_unf = 1'b1;
                if (m_state == 1) m_pc = (m_pc + 1) % MODV;
            end
        end else if (c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_back((m_pc + 1) % MODV);
                m_pc    = ja;
                m_state = 1;
            end else begin
                m_ovf = 1'b1;
                if (m_state == 1) m_pc = (m_pc + 1) % MODV;
            end
        end else if (j) begin
            m_pc    = ja;
            m_state = 1;
        end else if (m_state == 1) begin
            if (m_pc == LAST) m_state = 2;
            else              m_pc = m_pc + 1;
        end
    endtask

    task automatic check_all(input string where);
        check_eq({where, " pc"},      32'(program_counter), 32'(m_pc));
        check_eq({where, " running"}, 32'(running),         32'(m_state == 1));
        check_eq({where, " halted"},  32'(halted),          32'(m_state == 2));
        check_eq({where, " level"},   32'(stack_level),     32'(m_stk.size()));
        check_eq({where, " ovf"},     32'(stack_overflow),  32'(m_ovf));
        check_eq({where, " unf"},     32'(stack_underflow), 32'(m_unf));
    endtask

    // One clock: drive inputs, take the edge, advance model, compare 1ns later.
    task automatic cyc(input bit ld, input bit st, input bit j, input bit c,
                       input bit r, input int ja);
        load_done    = ld;
        stall        = st;
        jump_en      = j;
        call_en      = c;
        ret_en       = r;
        jump_address = AW'(ja);
        @(posedge CLK);
        model_step(ld, st, j, c, r, ja);
        #1;
        check_all("cyc");
    endtask

    // Reset pulse placed between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        #8;
        RST_N = 1'b1;

        // IDLE holds PC at 0 without load_done.
        cyc(0, 0, 0, 0, 0, 0);

        // Free run from 0 to 31, then hold in HALT.
        for (int k = 0; k < 36; k++) cyc(1, 0, 0, 0, 0, 0);
        check_eq("halt_pc", 32'(program_counter), 32'd31);
        check_eq("halt_flag", 32'(halted), 32'd1);

        // Jump out of HALT.
        cyc(1, 0, 1, 0, 0, 2);
        check_eq("halt_jump_pc", 32'(program_counter), 32'd2);
        check_eq("halt_jump_run", 32'(running), 32'd1);

        // Call at 3 to 20, return at 22 lands on 4.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 20);
        check_eq("call_pc", 32'(program_counter), 32'd20);
        check_eq("call_level", 32'(stack_level), 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("ret_pc", 32'(program_counter), 32'd4);
        check_eq("ret_level", 32'(stack_level), 32'd0);

        // Five nested calls: pushes 5, 11, 13, 15; fifth overflows.
        cyc(1, 0, 0, 1, 0, 10);
        cyc(1, 0, 0, 1, 0, 12);
        cyc(1, 0, 0, 1, 0, 14);
        cyc(1, 0, 0, 1, 0, 16);
        cyc(1, 0, 0, 1, 0, 25);
        check_eq("ovf_pc", 32'(program_counter), 32'd17);
        check_eq("ovf_flag", 32'(stack_overflow), 32'd1);
        check_eq("ovf_level", 32'(stack_level), 32'd4);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("pop1", 32'(program_counter), 32'd15);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("pop2", 32'(program_counter), 32'd13);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("pop3", 32'(program_counter), 32'd11);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("pop4", 32'(program_counter), 32'd5);

        // Underflow at 7.
        cyc(1, 0, 1, 0, 0, 7);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("unf_pc", 32'(program_counter), 32'd8);
        check_eq("unf_flag", 32'(stack_underflow), 32'd1);

        // Simultaneous ret+call+jump with one entry: pop only.
        cyc(1, 0, 0, 1, 0, 20);
        cyc(1, 0, 1, 1, 1, 3);
        check_eq("prio_pc", 32'(program_counter), 32'd9);
        check_eq("prio_level", 32'(stack_level), 32'd0);

        // Stall for three edges at 9.
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1, 0, 0, 0, 0);
            check_eq("stall_pc", 32'(program_counter), 32'd9);
        end
        cyc(1, 0, 0, 0, 0, 0);
        check_eq("unstall_pc", 32'(program_counter), 32'd10);

        // Call at 31 pushes the wrapped value 0; return lands on 0.
        cyc(1, 0, 1, 0, 0, 30);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 5);
        check_eq("call_at_last_run", 32'(running), 32'd1);
        cyc(1, 0, 0, 0, 1, 0);
        check_eq("wrap_pop", 32'(program_counter), 32'd0);

        // Async reset with PC=17, level=2.
        cyc(1, 0, 0, 1, 0, 15);
        cyc(1, 0, 0, 1, 0, 16);
        cyc(1, 0, 0, 0, 0, 0);
        check_eq("pre_rst_pc", 32'(program_counter), 32'd17);
        check_eq("pre_rst_level", 32'(stack_level), 32'd2);
        async_reset();
        check_eq("rst_pc", 32'(program_counter), 32'd0);
        check_eq("rst_unf", 32'(stack_underflow), 32'd0);

        // Dropping load_done in RUN returns to IDLE.
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check_eq("drop_pc", 32'(program_counter), 32'd0);
        check_eq("drop_running", 32'(running), 32'd0);

        // Randomized run.
        for (int k = 0; k < 3000; k++) begin
            bit ld, st, j, c, r;
            int ja;
            ld = ($urandom_range(0, 31) != 0);
            st = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 4) == 0);
            ja = int'($urandom_range(0, MODV - 1));
            cyc(ld, st, j, c, r, ja);
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
